// File: rtl/gate_sequence_detector_pkg.sv
// gate_pkg: shared types and constants for the parking-gate sequence detector.
//   gate_state_t          - direction-tracking FSM states (3-bit encoding)
//   GATE_DEBOUNCE_DEFAULT - default number of stable samples before a sensor
//                           value is accepted by the debounce filter
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    ERR  = 3'd7
  } gate_state_t;

  localparam int GATE_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/gate_sequence_detector_if.sv
// Sensor/event bundle between the gate sensors and the occupancy counter.
//   outer, inner : synchronized sensor levels (1 = blocked)
//   enter, exit  : one-cycle car-completed pulses
//   err          : one-cycle illegal-transition pulse
//   busy         : FSM is not idle
// master = sensor/counter side, slave = detector.
interface gate_sequence_detector_if;
  logic outer;
  logic inner;
  logic enter;
  logic exit;
  logic err;
  logic busy;

  modport master (output outer, inner, input enter, exit, err, busy);
  modport slave  (input outer, inner, output enter, exit, err, busy);
endinterface

// File: rtl/gate_sequence_detector_sensor_debounce.sv
// sensor_debounce: accepts a new raw sensor level only after it has been
// sampled DEBOUNCE_CYCLES times in a row; shorter glitches are dropped.
//   clk      : system clock
//   reset    : synchronous, active-low
//   raw      : synchronized sensor input
//   filtered : accepted (debounced) sensor level, registered
module sensor_debounce
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GATE_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // The sample that would bring the count to DEBOUNCE_CYCLES is the one that
  // accepts the new level, so a change first seen at edge k lands at edge
  // k+DEBOUNCE_CYCLES-1 and the counter restarts from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filtered <= 1'b0;
      cnt      <= '0;
    end else if (raw == filtered) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      filtered <= raw;
      cnt      <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sequence_detector.sv
// gate_sequence_detector: turns the outer/inner gate sensors into one-cycle
// enter/exit pulses. A car is counted only after crossing both sensors in
// order; reverse steps back up the FSM without counting.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : gate_sequence_detector_if.slave (outer, inner in; enter, exit,
//           err, busy out - all outputs registered)
// Build option: define GATE_DEBOUNCE_EN to insert a sensor_debounce filter
// on each sensor; otherwise the FSM sees the raw sensor levels directly.
module gate_sequence_detector
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = GATE_DEBOUNCE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  gate_sequence_detector_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end

  logic outer_f;
  logic inner_f;

  // ---- stage p0: sensor filtering ----
`ifdef GATE_DEBOUNCE_EN
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer_db (
    .clk      (clk),
    .reset    (reset),
    .raw      (bus.outer),
    .filtered (outer_f)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner_db (
    .clk      (clk),
    .reset    (reset),
    .raw      (bus.inner),
    .filtered (inner_f)
  );
`else
  assign outer_f = bus.outer;
  assign inner_f = bus.inner;
`endif

  logic [1:0]  pair_p0;
  gate_state_t state;
  gate_state_t state_next;
  logic        enter_next;
  logic        exit_next;
  logic        err_next;

  assign pair_p0 = {outer_f, inner_f};

  // ---- stage p1: direction FSM and registered outputs ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      bus.enter <= 1'b0;
      bus.exit  <= 1'b0;
      bus.err   <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_next;
      bus.enter <= enter_next;
      bus.exit  <= exit_next;
      bus.err   <= err_next;
      bus.busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    enter_next = 1'b0;
    exit_next  = 1'b0;
    unique case (state)
      IDLE: case (pair_p0)
        2'b10:   state_next = EN1;
        2'b01:   state_next = EX1;
        2'b11:   state_next = ERR;
        default: state_next = state;
      endcase
      EN1: case (pair_p0)
        2'b11:   state_next = EN2;
        2'b00:   state_next = IDLE;
        2'b01:   state_next = ERR;
        default: state_next = state;
      endcase
      EN2: case (pair_p0)
        2'b01:   state_next = EN3;
        2'b10:   state_next = EN1;
        2'b00:   state_next = ERR;
        default: state_next = state;
      endcase
      EN3: case (pair_p0)
        2'b00: begin
          state_next = IDLE;
          enter_next = 1'b1;
        end
        2'b11:   state_next = EN2;
        2'b10:   state_next = ERR;
        default: state_next = state;
      endcase
      EX1: case (pair_p0)
        2'b11:   state_next = EX2;
        2'b00:   state_next = IDLE;
        2'b10:   state_next = ERR;
        default: state_next = state;
      endcase
      EX2: case (pair_p0)
        2'b10:   state_next = EX3;
        2'b01:   state_next = EX1;
        2'b00:   state_next = ERR;
        default: state_next = state;
      endcase
      EX3: case (pair_p0)
        2'b00: begin
          state_next = IDLE;
          exit_next  = 1'b1;
        end
        2'b11:   state_next = EX2;
        2'b01:   state_next = ERR;
        default: state_next = state;
      endcase
      ERR: begin
        if (pair_p0 == 2'b00) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // err fires only on entry into ERR, never while parked there.
  assign err_next = (state_next == ERR) && (state != ERR);

endmodule

// File: tb/tb_gate_sequence_detector.sv
// Scoreboard bench for gate_sequence_detector. Works in either build: the
// expected pulse latency follows GATE_DEBOUNCE_EN (4 extra edges with the
// default DEBOUNCE_CYCLES=4, none without the filter).
module tb_gate_sequence_detector;

`ifdef GATE_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  localparam int K_ENTER = 0;
  localparam int K_EXIT  = 1;
  localparam int K_ERR   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t exp_q[$];

  gate_sequence_detector_if bus();

  gate_sequence_detector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Apply a sensor pair at a falling edge and hold it for 'hold' cycles.
  // A pulse expected from this pair is due after edge (first sample + LAT).
  task automatic drive(input logic [1:0] pair, input int hold, input int kind = -1);
    ev_t e;
    @(negedge clk);
    bus.outer = pair[1];
    bus.inner = pair[0];
    if (kind >= 0) begin
      e.kind = kind;
      e.at   = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic check_busy(input string name, input logic req);
    check(name, int'(bus.busy), int'(req));
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  act;
    if (bus.enter || bus.exit || bus.err) begin
      check("pulse_onehot", int'(bus.enter) + int'(bus.exit) + int'(bus.err), 1);
      act = bus.enter ? K_ENTER : (bus.exit ? K_EXIT : K_ERR);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", act, -1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", act, e.kind);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.outer = 1'b0;
    bus.inner = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enter", int'(bus.enter), 0);
    check("rst_exit",  int'(bus.exit),  0);
    check("rst_err",   int'(bus.err),   0);
    check("rst_busy",  int'(bus.busy),  0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // full entry
    drive(2'b10, 10); check_busy("t1_busy_en1", 1'b1);
    drive(2'b11, 10); check_busy("t1_busy_en2", 1'b1);
    drive(2'b01, 10); check_busy("t1_busy_en3", 1'b1);
    drive(2'b00, 10, K_ENTER); check_busy("t1_busy_idle", 1'b0);

    // full exit
    drive(2'b01, 10); check_busy("t2_busy_ex1", 1'b1);
    drive(2'b11, 10); check_busy("t2_busy_ex2", 1'b1);
    drive(2'b10, 10); check_busy("t2_busy_ex3", 1'b1);
    drive(2'b00, 10, K_EXIT); check_busy("t2_busy_idle", 1'b0);

    // back up out of the gate: no count
    drive(2'b10, 10); check_busy("t3_busy_en1", 1'b1);
    drive(2'b11, 10); check_busy("t3_busy_en2", 1'b1);
    drive(2'b10, 10); check_busy("t3_busy_back", 1'b1);
    drive(2'b00, 10); check_busy("t3_busy_idle", 1'b0);

    // 3-cycle glitch on outer: filtered away only when debounce is built in
    drive(2'b10, 3); check_busy("t4_busy_glitch", (LAT == 0) ? 1'b1 : 1'b0);
    drive(2'b00, 10); check_busy("t4_busy_after", 1'b0);

    // both sensors at once is illegal; err once, stay busy until 00
    drive(2'b00, 10);
    drive(2'b11, 10, K_ERR); check_busy("t5_busy_err", 1'b1);
    drive(2'b10, 10); check_busy("t5_busy_err_hold", 1'b1);
    drive(2'b00, 10); check_busy("t5_busy_idle", 1'b0);

    // reset mid-car: partial entry is discarded
    drive(2'b10, 10);
    drive(2'b11, 10); check_busy("t6_busy_en2", 1'b1);
    @(negedge clk);
    reset     = 1'b0;
    bus.outer = 1'b0;
    bus.inner = 1'b0;
    @(negedge clk);
    check("t6_rst_enter", int'(bus.enter), 0);
    check("t6_rst_exit",  int'(bus.exit),  0);
    check("t6_rst_err",   int'(bus.err),   0);
    check("t6_rst_busy",  int'(bus.busy),  0);
    reset = 1'b1;
    drive(2'b00, 10); check_busy("t6_busy_post", 1'b0);
    drive(2'b10, 10);
    drive(2'b11, 10);
    drive(2'b01, 10);
    drive(2'b00, 10, K_ENTER); check_busy("t6_busy_idle", 1'b0);

    repeat (20) @(negedge clk);
    check("pending_pulses", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_sequence_detector.md
# gate_sequence_detector

Decodes the two parking-gate sensors (outer, inner) into one-cycle `enter` and `exit` event pulses for the occupancy counter. It sits between the two-flop sensor synchronizers and the car counter. A per-sensor debounce filter rejects switch bounce. A direction-tracking FSM counts a car only after it has fully crossed both sensors in order, and tolerates backing up.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive samples a raw sensor value must hold before it is accepted; legal range 1–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset), sampled on `clk`.
- `outer`  in  1  synchronized outer sensor; 1 = blocked.
- `inner`  in  1  synchronized inner sensor; 1 = blocked.
- `enter`  out  1  registered one-cycle pulse: a car completed entry.
- `exit`  out  1  registered one-cycle pulse: a car completed exit.
- `err`  out  1  registered one-cycle pulse: an illegal sensor transition was seen.
- `busy`  out  1  registered; 1 whenever the FSM is not in IDLE.

## Operation
- Filtered pair is written {o,i}, with o = filtered outer and i = filtered inner.
- FSM states and transitions. Any pair not listed keeps the current state.
  - IDLE: 10→EN1; 01→EX1; 11→ERR.
  - EN1: 11→EN2; 00→IDLE (no count); 01→ERR.
  - EN2: 01→EN3; 10→EN1; 00→ERR.
  - EN3: 00→IDLE and pulse `enter`; 11→EN2; 10→ERR.
  - EX1: 11→EX2; 00→IDLE (no count); 10→ERR.
  - EX2: 10→EX3; 01→EX1; 00→ERR.
  - EX3: 00→IDLE and pulse `exit`; 11→EX2; 01→ERR.
  - ERR: 00→IDLE; any other pair stays in ERR.
- Backtracking (a reverse step) returns to the previous state and produces no pulse.
- `err` pulses once, on the transition into ERR. It does not re-pulse while the FSM stays in ERR.
- `enter`, `exit` and `err` are mutually exclusive. At most one is high in any cycle.
- Debounce, per sensor:
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while raw ≠ filtered and clears when raw = filtered.
  - When the counter reaches DEBOUNCE_CYCLES, filtered takes the raw value and the counter clears.
  - The counter saturates; it never wraps.
- Reset sets: FSM to IDLE, filtered values to 0, counters to 0, and all outputs to 0.
- A car that is partway through the gate at reset is never counted.
- If sensors are still blocked after reset, the FSM follows the normal table from IDLE. For example, both sensors accepted on the same edge gives IDLE→ERR with an `err` pulse.

## Timing
- All outputs are registered. The reset value of every output is 0.
- Assertion of `reset` (low) at edge k: all outputs are 0 from edge k.
- With debounce:
  - A raw change first sampled at edge k, held stably, updates filtered at edge k+DEBOUNCE_CYCLES−1.
  - The FSM and its output pulse update at edge k+DEBOUNCE_CYCLES.
- Without debounce: the FSM acts on the raw value sampled at edge k, and its output is visible after edge k.
- A raw glitch shorter than DEBOUNCE_CYCLES samples never changes filtered.
- Pulse width is exactly 1 cycle. Back-to-back cars produce separate pulses at least 4 FSM transitions apart.

## Configuration
- `GATE_DEBOUNCE_EN` defined: both debounce filters are instantiated and `DEBOUNCE_CYCLES` applies.
- `GATE_DEBOUNCE_EN` undefined: filtered = raw (direct wire). There are no counters, `DEBOUNCE_CYCLES` is ignored, and latency is 1 edge.
- The FSM table and the outputs are identical in both builds.

## Structure
- Package `gate_pkg` holds:
  - `gate_state_t`: enum of IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR; 3-bit encoding.
  - `GATE_DEBOUNCE_DEFAULT` = 4.
- Sub-module `sensor_debounce` (clk, reset, raw, filtered; parameter DEBOUNCE_CYCLES) is instantiated twice, once per sensor, under `GATE_DEBOUNCE_EN`.
- The top level holds the FSM and the output registers.

## Test plan
1. Debounce on, N=4. Drive pairs 10, 11, 01, 00, each held 10 cycles. Required: exactly one `enter` pulse, 4 edges after 00 is applied; `exit` = `err` = 0; `busy` = 0 afterwards.
2. Drive pairs 01, 11, 10, 00, each held 10 cycles. Required: one `exit` pulse; `enter` = 0.
3. Backtrack: drive 10, 11, 10, 00. Required: no pulses; `busy` rises, then returns to 0.
4. Debounce on, N=4. Pulse `outer` high for 3 cycles only. Required: no state change; `busy` stays 0.
   Repeat with the macro off. Required: `busy` rises.
5. Drive 00 then 11. Required: `err` high for exactly 1 cycle. `busy` stays 1 while 11 is held and through a 11→10 change. After 00 is accepted, `busy` = 0.
6. Reach EN2, then hold `reset` = 0 for 1 cycle while sensors go to 00. Required: all outputs 0 and no `enter` pulse. A subsequent full entry counts once.
